// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op encoding, FSM states and the command/result views.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OpNop  = 3'b000,
        OpAdd  = 3'b001,
        OpSub  = 3'b010,
        OpAnd  = 3'b011,
        OpXor  = 3'b100,
        OpMul  = 3'b101,
        OpShl  = 3'b110,
        OpRsvd = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } alu_state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        alu_op_e              op_code;
    } alu_cmd_t;

    typedef struct packed {
        logic                 ready;
        logic                 carry;
        logic [ALU_WIDTH-1:0] out;
    } alu_rslt_t;

    function automatic logic alu_is_multi_cycle(alu_op_e op);
        return op == OpMul;
    endfunction

endpackage

// File: rtl/alu_core_if.sv
// Command/result bus of the ALU; master drives commands, slave (the ALU) returns results.
interface alu_core_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          op_code;
    logic             busy;
    logic             ready;
    logic             carry;
    logic [WIDTH-1:0] out;

    modport master (
        output start, a, b, op_code,
        input  busy, ready, carry, out
    );

    modport slave (
        input  start, a, b, op_code,
        output busy, ready, carry, out
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per step, WIDTH steps per product.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               step_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Saturate so a stray extra step can never wrap the count.
            if (cnt_q != CntLast) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done_o    = step_i && (cnt_q == CntLast);
    // Post-step value, so the edge that retires the last step can capture the full product.
    assign product_o = acc_d;

endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU: single-cycle ops retire in one clock, MUL iterates in alu_mul_seq.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_core_if.slave bus
);

    localparam int unsigned ShW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               accept;
    logic               mul_load;
    logic               mul_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     single_res;
    logic [ShW-1:0]     sh;

    // A start seen in the DONE cycle is taken directly, since busy is already low there.
    assign accept = (state_q != StMul) && bus.start && (bus.op_code != OpNop);
    assign sh     = bus.b[ShW-1:0];

    // Bit WIDTH carries the ADD carry, SUB borrow and the last bit shifted out by SHL.
    always_comb begin
        single_res = '0;
        case (bus.op_code)
            OpAdd:   single_res = {1'b0, bus.a} + {1'b0, bus.b};
            OpSub:   single_res = {1'b0, bus.a} - {1'b0, bus.b};
            OpAnd:   single_res = {1'b0, bus.a & bus.b};
            OpXor:   single_res = {1'b0, bus.a ^ bus.b};
            OpShl:   single_res = {1'b0, bus.a} << sh;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    if (alu_is_multi_cycle(bus.op_code)) begin
                        mul_load = 1'b1;
                        state_d  = StMul;
                    end else begin
                        out_d   = single_res[WIDTH-1:0];
                        carry_d = single_res[WIDTH];
                        state_d = StDone;
                    end
                end
            end
            StMul: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    out_d   = mul_product[WIDTH-1:0];
                    carry_d = |mul_product[2*WIDTH-1:WIDTH];
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (mul_load),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .step_i   (mul_step),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    assign bus.busy  = (state_q == StMul);
    assign bus.ready = (state_q == StDone);
    assign bus.carry = carry_q;
    assign bus.out   = out_q;

endmodule
